// File: rtl/registro_paralelo_multietapa.sv
// Multi-stage audio sample register: hold / load / shift / rotate over DEPTH
// WIDTH-bit stages, with a selectable tap, a saturating fill level and a full flag.

module registro_etapa #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end
endmodule

module registro_paralelo_multietapa #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int TAP_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk44kHz,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] datoIn,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] datoOut,
  output logic [WIDTH-1:0] datoTap,
  output logic [CNT_W-1:0] nivel,
  output logic             lleno
);
  localparam int TAPS = 2 ** TAP_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    M_HOLD   = 2'b00,
    M_LOAD   = 2'b01,
    M_SHIFT  = 2'b10,
    M_ROTATE = 2'b11
  } modo_t;

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [TAPS-1:0][WIDTH-1:0]  tap_tbl;
  logic [CNT_W-1:0]            nivel_q, nivel_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    registro_etapa #(.WIDTH(WIDTH)) u_etapa (
      .clk   (clk44kHz),
      .rst_n (reset),
      .d     (stage_d[k]),
      .q     (stage_q[k])
    );
  end

  always_ff @(posedge clk44kHz or negedge reset) begin
    if (!reset) nivel_q <= '0;
    else        nivel_q <= nivel_d;
  end

  always_comb begin
    stage_d = stage_q;
    nivel_d = nivel_q;
    if (enable) begin
      if (clear) begin
        stage_d = '0;
        nivel_d = '0;
      end else begin
        case (modo_t'(modo))
          M_LOAD: begin
            stage_d[0] = datoIn;
            if (nivel_q == '0) nivel_d = CNT_W'(1);
          end
          M_SHIFT: begin
            stage_d[0] = datoIn;
            for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
            if (nivel_q < FULL) nivel_d = nivel_q + CNT_W'(1);
          end
          M_ROTATE: begin
            stage_d[0] = stage_q[DEPTH-1];
            for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
          end
          default: ;
        endcase
      end
    end
  end

  // Zero-padded view so any tap_sel value indexes a defined entry.
  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    if (t < DEPTH) begin : g_real
      assign tap_tbl[t] = stage_q[t];
    end else begin : g_pad
      assign tap_tbl[t] = '0;
    end
  end

  assign datoOut = stage_q[DEPTH-1];
  assign datoTap = tap_tbl[tap_sel];
  assign nivel   = nivel_q;
  assign lleno   = (nivel_q == FULL);
endmodule

// File: tb/tb_registro_paralelo_multietapa.sv
// Bench for registro_paralelo_multietapa: directed vector table, reset corner
// sequences, then random traffic checked against a queue-based model.

module tb_registro_paralelo_multietapa;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int TAP_W = 4;
  localparam int CNT_W = 4;

  logic             clk44kHz = 0;
  logic             reset;
  logic             enable, clear;
  logic [1:0]       modo;
  logic [WIDTH-1:0] datoIn;
  logic [TAP_W-1:0] tap_sel;
  logic [WIDTH-1:0] datoOut, datoTap;
  logic [CNT_W-1:0] nivel;
  logic             lleno;

  registro_paralelo_multietapa #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TAP_W(TAP_W), .CNT_W(CNT_W)
  ) dut (
    .clk44kHz (clk44kHz),
    .reset    (reset),
    .enable   (enable),
    .clear    (clear),
    .modo     (modo),
    .datoIn   (datoIn),
    .tap_sel  (tap_sel),
    .datoOut  (datoOut),
    .datoTap  (datoTap),
    .nivel    (nivel),
    .lleno    (lleno)
  );

  always #5 clk44kHz = ~clk44kHz;

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] md;
    logic [3:0] din;
    logic [3:0] tap;
    logic [3:0] out;
    logic [3:0] tapv;
    logic [3:0] niv;
    logic       ll;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [WIDTH-1:0] mdl[$];
  int   mdl_lvl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] o, input logic [3:0] t,
                         input logic [3:0] n, input logic l);
    chk({tag, ".datoOut"}, 32'(datoOut), 32'(o));
    chk({tag, ".datoTap"}, 32'(datoTap), 32'(t));
    chk({tag, ".nivel"},   32'(nivel),   32'(n));
    chk({tag, ".lleno"},   32'(lleno),   32'(l));
  endtask

  task automatic add(input logic en, input logic clr, input logic [1:0] md,
                     input logic [3:0] din, input logic [3:0] tap, input logic [3:0] o,
                     input logic [3:0] tv, input logic [3:0] n, input logic l);
    vec_t v;
    v.en = en; v.clr = clr; v.md = md; v.din = din; v.tap = tap;
    v.out = o; v.tapv = tv; v.niv = n; v.ll = l;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic en, input logic clr, input logic [1:0] md,
                       input logic [3:0] din, input logic [3:0] tap);
    enable = en; clear = clr; modo = md; datoIn = din; tap_sel = tap;
  endtask

  // Reference model: stages as a queue, index 0 = stage 0.
  task automatic model_step(input logic en, input logic clr, input logic [1:0] md,
                            input logic [3:0] din);
    logic [WIDTH-1:0] last;
    if (!en) return;
    if (clr) begin
      foreach (mdl[i]) mdl[i] = '0;
      mdl_lvl = 0;
      return;
    end
    case (md)
      2'b01: begin mdl[0] = din; if (mdl_lvl < 1) mdl_lvl = 1; end
      2'b10: begin
        void'(mdl.pop_back());
        mdl.push_front(din);
        mdl_lvl = (mdl_lvl + 1 > DEPTH) ? DEPTH : mdl_lvl + 1;
      end
      2'b11: begin last = mdl.pop_back(); mdl.push_front(last); end
      default: ;
    endcase
  endtask

  initial begin
    reset = 0;
    drive(1, 0, 2'b10, 4'hA, 0);
    #1 chk_all("rst_init", 0, 0, 0, 0);

    // Reset held low while shifting is requested.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk44kHz); #1;
      chk_all("rst_hold", 0, 0, 0, 0);
    end
    reset = 1;
    @(posedge clk44kHz); #1;
    chk_all("rst_first", 0, 4'hA, 1, 0);

    // Directed table; first row clears, then fill 1..8.
    add(1, 1, 2'b10, 4'h3, 0, 0, 0, 0, 0);
    add(1, 0, 2'b10, 4'd1, 0, 0, 1, 1, 0);
    add(1, 0, 2'b10, 4'd2, 1, 0, 1, 2, 0);
    add(1, 0, 2'b10, 4'd3, 2, 0, 1, 3, 0);
    add(1, 0, 2'b10, 4'd4, 0, 0, 4, 4, 0);
    add(1, 0, 2'b10, 4'd5, 4, 0, 1, 5, 0);
    add(1, 0, 2'b10, 4'd6, 0, 0, 6, 6, 0);
    add(1, 0, 2'b10, 4'd7, 6, 0, 1, 7, 0);
    add(1, 0, 2'b10, 4'd8, 7, 1, 1, 8, 1);
    add(0, 1, 2'b10, 4'hF, 0, 1, 8, 8, 1);
    add(0, 1, 2'b10, 4'hF, 0, 1, 8, 8, 1);
    add(1, 0, 2'b00, 4'hF, 3, 1, 5, 8, 1);
    add(1, 0, 2'b11, 4'hF, 0, 2, 1, 8, 1);
    for (int r = 2; r <= 7; r++) add(1, 0, 2'b11, 4'hF, 0, 4'(r + 1), 4'(r), 8, 1);
    add(1, 0, 2'b11, 4'hF, 0, 1, 8, 8, 1);
    add(1, 0, 2'b10, 4'd9, 0, 2, 9, 8, 1);
    add(1, 0, 2'b00, 4'd0, 9, 2, 0, 8, 1);
    add(1, 0, 2'b00, 4'd0, 15, 2, 0, 8, 1);
    add(1, 1, 2'b10, 4'd7, 0, 0, 0, 0, 0);
    add(1, 0, 2'b01, 4'd5, 0, 0, 5, 1, 0);
    add(1, 0, 2'b01, 4'd6, 1, 0, 0, 1, 0);
    add(1, 0, 2'b01, 4'd4, 0, 0, 4, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].md, tbl[i].din, tbl[i].tap);
      @(posedge clk44kHz); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].out, tbl[i].tapv, tbl[i].niv, tbl[i].ll);
    end

    // Asynchronous reset between edges while shifting.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2'b10, 4'd7, 0);
      @(posedge clk44kHz); #1;
    end
    #2 reset = 0;
    #1 chk_all("rst_async", 0, 0, 0, 0);
    @(posedge clk44kHz); #1;
    chk_all("rst_async_hold", 0, 0, 0, 0);
    reset = 1;

    // Random traffic against the model.
    mdl.delete();
    for (int i = 0; i < DEPTH; i++) mdl.push_back('0);
    mdl_lvl = 0;
    for (int i = 0; i < 400; i++) begin
      logic       en, clr;
      logic [1:0] md;
      logic [3:0] din, tap, et;
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      md  = 2'($urandom_range(0, 3));
      din = 4'($urandom_range(0, 15));
      tap = 4'($urandom_range(0, 15));
      drive(en, clr, md, din, tap);
      @(posedge clk44kHz);
      model_step(en, clr, md, din);
      #1;
      et = (tap < DEPTH) ? mdl[tap] : 4'h0;
      chk_all($sformatf("rnd%0d", i), mdl[DEPTH-1], et, 4'(mdl_lvl), mdl_lvl == DEPTH);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
